// File: rtl/crd_stream_pkg.sv
// Shared types, widths and token encoders for the crd stream transmitter.
package crd_stream_pkg;

  localparam int TOKEN_W = 17;
  localparam int DATA_W  = 16;
  localparam int KIND_W  = 2;
  localparam int ENTRY_W = DATA_W + KIND_W;
  localparam logic [TOKEN_W-1:0] DONE_TOKEN = 17'h10100;

  typedef enum logic [KIND_W-1:0] {
    COORD   = 2'b00,
    STOP    = 2'b01,
    DONE    = 2'b10,
    ILLEGAL = 2'b11
  } kind_e;

  typedef enum logic [1:0] {
    ACTIVE   = 2'b00,
    DRAIN    = 2'b01,
    FINISHED = 2'b10
  } state_e;

  function automatic logic [TOKEN_W-1:0] encode_coord(input logic [DATA_W-1:0] value);
    return {1'b0, value};
  endfunction

  function automatic logic [TOKEN_W-1:0] encode_stop(input logic [7:0] lvl);
    return {1'b1, 6'b0, 2'b00, lvl};
  endfunction

  function automatic logic [TOKEN_W-1:0] encode_done();
    return DONE_TOKEN;
  endfunction

endpackage

// File: rtl/crd_stream_fifo.sv
// Small item FIFO (data + kind) with full/empty flags and synchronous flush.
module crd_stream_fifo
  import crd_stream_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_en,
  input  logic               flush,
  input  logic               push,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic               pop,
  output logic [ENTRY_W-1:0] rdata,
  output logic               full,
  output logic               empty
);

  localparam int AW = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic               do_push;
  logic               do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clk_en) begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
        if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clk_en && !flush && do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/crd_stream_tx.sv
// Typed-item to 17-bit coordinate stream transmitter with stop merging.
module crd_stream_tx
  import crd_stream_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter bit MERGE_STOPS = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_en,
  input  logic               flush,
  input  logic               tile_en,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [KIND_W-1:0]  in_kind,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [TOKEN_W-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               done,
  output logic               err,
  output logic [15:0]        tok_count,
  output state_e             state
);

  state_e               state_q;
  state_e               state_next;
  logic                 alive_q;
  logic [TOKEN_W-1:0]   out_data_q;
  logic                 out_valid_q;
  logic                 pend_valid_q;
  logic [7:0]           pend_lvl_q;
  logic                 done_q;
  logic                 err_q;
  logic [15:0]          tok_count_q;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic [ENTRY_W-1:0]   head;
  kind_e                head_kind;
  logic [DATA_W-1:0]    head_data;
  logic                 accept;
  logic                 push;
  logic                 hs;
  logic                 load_opp;
  logic                 head_avail;
  logic                 merge_stop;
  logic                 emit_pend;
  logic                 pop;
  logic                 load;
  logic [TOKEN_W-1:0]   load_data;
  logic [7:0]           merged_lvl;

  // Both sides: a transfer happens on a clock edge where valid and ready are
  // both high; a valid token never changes or retracts until it transfers.
  assign in_ready  = alive_q && tile_en && !fifo_full && (state_q == ACTIVE);
  assign accept    = in_valid && in_ready;
  assign push      = accept && (in_kind != ILLEGAL);
  assign out_valid = out_valid_q && tile_en;
  assign hs        = out_valid && out_ready;
  assign head_kind = kind_e'(head[ENTRY_W-1:DATA_W]);
  assign head_data = head[DATA_W-1:0];

  crd_stream_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .flush  (flush),
    .push   (push),
    .wdata  ({in_kind, in_data}),
    .pop    (pop),
    .rdata  (head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_comb begin
    state_next = state_q;
    load_opp   = tile_en && (state_q == ACTIVE) && (!out_valid_q || out_ready);
    head_avail = load_opp && !fifo_empty;
    merge_stop = MERGE_STOPS && head_avail && (head_kind == STOP);
    // A held stop must go out before the non-stop item behind it.
    emit_pend  = MERGE_STOPS && head_avail && pend_valid_q && (head_kind != STOP);
    pop        = head_avail && !emit_pend;
    load       = head_avail && !merge_stop;
    merged_lvl = (pend_valid_q && (pend_lvl_q > head_data[7:0])) ? pend_lvl_q : head_data[7:0];
    load_data  = encode_coord(head_data);
    if (emit_pend)              load_data = encode_stop(pend_lvl_q);
    else if (head_kind == STOP) load_data = encode_stop(head_data[7:0]);
    else if (head_kind == DONE) load_data = encode_done();

    if (flush) begin
      state_next = ACTIVE;
    end else begin
      case (state_q)
        ACTIVE:   if (pop && head_kind == DONE) state_next = DRAIN;
        DRAIN:    if (hs) state_next = FINISHED;
        FINISHED: state_next = FINISHED;
        default:  state_next = ACTIVE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         state_q <= ACTIVE;
    else if (clk_en) state_q <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alive_q      <= 1'b0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_lvl_q   <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      tok_count_q  <= '0;
    end else if (clk_en) begin
      alive_q <= 1'b1;
      if (flush) begin
        out_valid_q  <= 1'b0;
        pend_valid_q <= 1'b0;
        tok_count_q  <= '0;
      end else begin
        if (accept && in_kind == ILLEGAL) err_q <= 1'b1;
        if (hs) tok_count_q <= tok_count_q + 16'd1;
        if (hs && state_q == DRAIN) done_q <= 1'b1;
        if (load) begin
          out_data_q  <= load_data;
          out_valid_q <= 1'b1;
        end else if (hs) begin
          out_valid_q <= 1'b0;
        end
        if (emit_pend) begin
          pend_valid_q <= 1'b0;
        end else if (merge_stop) begin
          pend_valid_q <= 1'b1;
          pend_lvl_q   <= merged_lvl;
        end
      end
    end
  end

  assign out_data  = out_data_q;
  assign done      = done_q;
  assign err       = err_q;
  assign tok_count = tok_count_q;
  assign state     = state_q;

endmodule

// File: tb/tb_crd_stream_tx.sv
// Directed bench for crd_stream_tx: one merging and one pass-through instance.
module tb_crd_stream_tx;
  import crd_stream_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_en = 1'b1;
  logic        flush = 1'b0;
  logic        tile_en = 1'b1;
  logic [15:0] in_data = '0;
  logic [1:0]  in_kind = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready_m, out_valid_m, done_m, err_m;
  logic [16:0] out_data_m;
  logic [15:0] tok_count_m;
  state_e      state_m;
  logic        in_ready_n, out_valid_n, done_n, err_n;
  logic [16:0] out_data_n;
  logic [15:0] tok_count_n;
  state_e      state_n;

  int tests_run = 0;
  int tests_failed = 0;
  logic [16:0] exp_q[$];
  logic [16:0] cap_m[$];
  logic [16:0] cap_n[$];

  always #5 clk = ~clk;

  crd_stream_tx #(.DEPTH(4), .MERGE_STOPS(1'b1)) dut_m (
    .clk(clk), .rst(rst), .clk_en(clk_en), .flush(flush), .tile_en(tile_en),
    .in_data(in_data), .in_kind(in_kind), .in_valid(in_valid), .in_ready(in_ready_m),
    .out_data(out_data_m), .out_valid(out_valid_m), .out_ready(out_ready),
    .done(done_m), .err(err_m), .tok_count(tok_count_m), .state(state_m)
  );

  crd_stream_tx #(.DEPTH(4), .MERGE_STOPS(1'b0)) dut_n (
    .clk(clk), .rst(rst), .clk_en(clk_en), .flush(flush), .tile_en(tile_en),
    .in_data(in_data), .in_kind(in_kind), .in_valid(in_valid), .in_ready(in_ready_n),
    .out_data(out_data_n), .out_valid(out_valid_n), .out_ready(out_ready),
    .done(done_n), .err(err_n), .tok_count(tok_count_n), .state(state_n)
  );

  // Tokens seen valid and ready mid-cycle transfer on the next rising edge.
  always @(negedge clk) begin
    if (clk_en && !rst && !flush) begin
      if (out_valid_m && out_ready) cap_m.push_back(out_data_m);
      if (out_valid_n && out_ready) cap_n.push_back(out_data_n);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task push_item(input logic [1:0] kind, input logic [15:0] data, input int budget, output bit ok);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_kind  = kind;
    in_data  = data;
    while (!in_ready_m && n < budget) begin
      tick(1);
      n++;
    end
    ok = in_ready_m;
    if (ok) tick(1);
    in_valid = 1'b0;
  endtask

  task push_ok(input logic [1:0] kind, input logic [15:0] data);
    bit ok;
    push_item(kind, data, 20, ok);
    check("push_accept", 32'(ok), 32'd1);
  endtask

  task do_flush();
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
  endtask

  task wait_finished();
    int n;
    n = 0;
    while (state_m != FINISHED && n < 40) begin
      tick(1);
      n++;
    end
  endtask

  task expect_seq(input bit use_n, input int base, input string tag);
    int sz;
    sz = use_n ? cap_n.size() - base : cap_m.size() - base;
    check({tag, "_len"}, 32'(sz), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < sz; i++)
      check(tag, 32'(use_n ? cap_n[base+i] : cap_m[base+i]), 32'(exp_q[i]));
    exp_q.delete();
  endtask

  initial begin
    int bm, bn, lat, acc;
    bit ok;

    // Reset
    tick(2);
    check("rst_out_valid", 32'(out_valid_m), 32'd0);
    check("rst_in_ready", 32'(in_ready_m), 32'd0);
    check("rst_done", 32'(done_m), 32'd0);
    check("rst_err", 32'(err_m), 32'd0);
    check("rst_tok_count", 32'(tok_count_m), 32'd0);
    check("rst_out_data", 32'(out_data_m), 32'd0);
    check("rst_state", 32'(state_m), 32'(ACTIVE));
    rst = 1'b0;
    check("ready_at_release", 32'(in_ready_m), 32'd0);
    tick(1);
    check("ready_after_release", 32'(in_ready_m), 32'd1);

    // Basic sequence with latency check
    out_ready = 1'b1;
    bm = cap_m.size();
    bn = cap_n.size();
    push_ok(COORD, 16'd3);
    lat = 1;
    while (lat < 8) begin
      @(negedge clk);
      if (out_valid_m) break;
      lat++;
    end
    check("first_latency", 32'(lat), 32'd2);
    tick(1);
    push_ok(COORD, 16'd7);
    push_ok(STOP, 16'd0);
    push_ok(DONE, 16'd0);
    wait_finished();
    check("t1_state", 32'(state_m), 32'(FINISHED));
    check("t1_done", 32'(done_m), 32'd1);
    check("t1_tok_count", 32'(tok_count_m), 32'd4);
    check("t1_in_ready", 32'(in_ready_m), 32'd0);
    check("t1_out_valid", 32'(out_valid_m), 32'd0);
    exp_q = '{17'h00003, 17'h00007, 17'h10000, 17'h10100};
    expect_seq(1'b0, bm, "t1_seq_m");
    exp_q = '{17'h00003, 17'h00007, 17'h10000, 17'h10100};
    expect_seq(1'b1, bn, "t1_seq_n");
    do_flush();

    // Stop merging vs pass-through
    bm = cap_m.size();
    bn = cap_n.size();
    push_ok(STOP, 16'd0);
    push_ok(STOP, 16'd1);
    push_ok(STOP, 16'd0);
    push_ok(COORD, 16'd5);
    tick(10);
    exp_q = '{17'h10001, 17'h00005};
    expect_seq(1'b0, bm, "t2_merge");
    exp_q = '{17'h10000, 17'h10001, 17'h10000, 17'h00005};
    expect_seq(1'b1, bn, "t2_nomerge");
    check("t2_tok_count", 32'(tok_count_m), 32'd2);
    do_flush();

    // Backpressure: FIFO plus output register hold five items
    out_ready = 1'b0;
    bm = cap_m.size();
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      push_item(COORD, 16'h0010 + 16'(i), 3, ok);
      if (ok) acc++;
    end
    check("t3_accepts", 32'(acc), 32'd5);
    check("t3_in_ready", 32'(in_ready_m), 32'd0);
    check("t3_out_valid", 32'(out_valid_m), 32'd1);
    check("t3_out_data", 32'(out_data_m), 32'h00010);
    tick(3);
    check("t3_out_stable", 32'(out_data_m), 32'h00010);
    out_ready = 1'b1;
    tick(10);
    exp_q = '{17'h00010, 17'h00011, 17'h00012, 17'h00013, 17'h00014};
    expect_seq(1'b0, bm, "t3_drain");
    check("t3_tok_count", 32'(tok_count_m), 32'd5);
    do_flush();

    // Pending stop followed by done
    bm = cap_m.size();
    push_ok(STOP, 16'd2);
    push_ok(DONE, 16'd0);
    wait_finished();
    check("t4_state", 32'(state_m), 32'(FINISHED));
    check("t4_in_ready", 32'(in_ready_m), 32'd0);
    check("t4_done", 32'(done_m), 32'd1);
    check("t4_tok_count", 32'(tok_count_m), 32'd2);
    exp_q = '{17'h10002, 17'h10100};
    expect_seq(1'b0, bm, "t4_seq");
    do_flush();
    check("t4_flush_state", 32'(state_m), 32'(ACTIVE));

    // Flush with queued items and a stop waiting at the output
    out_ready = 1'b0;
    push_ok(STOP, 16'd4);
    push_ok(COORD, 16'd1);
    push_ok(COORD, 16'd2);
    push_ok(COORD, 16'd3);
    tick(2);
    check("t5_pre_valid", 32'(out_valid_m), 32'd1);
    check("t5_pre_data", 32'(out_data_m), 32'h10004);
    do_flush();
    check("t5_flush_valid", 32'(out_valid_m), 32'd0);
    check("t5_flush_tok", 32'(tok_count_m), 32'd0);
    check("t5_flush_ready", 32'(in_ready_m), 32'd1);
    out_ready = 1'b1;
    bm = cap_m.size();
    push_ok(COORD, 16'd9);
    tick(5);
    exp_q = '{17'h00009};
    expect_seq(1'b0, bm, "t5_after");

    // Illegal kind is dropped and flagged
    bm = cap_m.size();
    push_ok(COORD, 16'h0020);
    push_ok(ILLEGAL, 16'h0055);
    push_ok(COORD, 16'h0021);
    tick(6);
    check("t6_err", 32'(err_m), 32'd1);
    check("t6_tok_count", 32'(tok_count_m), 32'd3);
    exp_q = '{17'h00020, 17'h00021};
    expect_seq(1'b0, bm, "t6_seq");

    // tile_en, clk_en and asynchronous reset mid-stream
    out_ready = 1'b0;
    push_ok(COORD, 16'h0030);
    tick(3);
    check("t7_valid", 32'(out_valid_m), 32'd1);
    tile_en = 1'b0;
    #1;
    check("t7_tile_valid", 32'(out_valid_m), 32'd0);
    check("t7_tile_ready", 32'(in_ready_m), 32'd0);
    tile_en = 1'b1;
    clk_en = 1'b0;
    out_ready = 1'b1;
    tick(3);
    check("t7_clken_valid", 32'(out_valid_m), 32'd1);
    check("t7_clken_data", 32'(out_data_m), 32'h00030);
    check("t7_clken_tok", 32'(tok_count_m), 32'd3);
    out_ready = 1'b0;
    clk_en = 1'b1;
    tick(1);
    rst = 1'b1;
    #1;
    check("t7_rst_valid", 32'(out_valid_m), 32'd0);
    check("t7_rst_err", 32'(err_m), 32'd0);
    check("t7_rst_tok", 32'(tok_count_m), 32'd0);
    tick(1);
    rst = 1'b0;
    tick(2);
    out_ready = 1'b1;
    bm = cap_m.size();
    push_ok(COORD, 16'h0031);
    tick(5);
    exp_q = '{17'h00031};
    expect_seq(1'b0, bm, "t7_after_rst");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/crd_stream_tx.md
Name: crd_stream_tx

Overview:
- Synthesizable transmitter for the 17-bit sparse coordinate stream consumed by crddrop and the other stream-processing tiles.
- Accepts typed items (coordinate, stop, done) from a producer through a small FIFO.
- Merges back-to-back stop tokens, then drives the ready/valid stream out of a single output register.
- Acts as the hardware counterpart of the bench tile_write source, for use as a GLB-side or on-tile stream originator.

Parameters:
DEPTH, 4, input FIFO entries (power of two, >= 2)
MERGE_STOPS, 1, 1 = consecutive stops collapse to one stop carrying the max level; 0 = stops passed unmodified

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
clk_en  in  1  gates every state update
flush  in  1  synchronous clear of FIFO, pending stop, FSM, counters
tile_en  in  1  0 = block inert: in_ready=0, out_valid=0, state held
in_data  in  16  coordinate value, or stop level in [7:0]
in_kind  in  2  00 coord, 01 stop, 10 done, 11 illegal
in_valid  in  1  producer item valid
in_ready  out  1  item accepted when in_valid & in_ready
out_data  out  17  stream token
out_valid  out  1  token valid
out_ready  in  1  downstream ready
done  out  1  sticky; done token handshaken
err  out  1  sticky; illegal kind received
tok_count  out  16  tokens handshaken on out, wraps at 2^16

Behaviour:
- Token encoding:
  - coord = {1'b0, data}
  - stop = {1'b1, 6'b0, 2'b00, lvl[7:0]}
  - done = 17'h10100
- Reset (async, rst=1): out_data=0, out_valid=0, in_ready=0, done=0, err=0, tok_count=0, FSM=ACTIVE, FIFO empty, pending-stop invalid. in_ready rises on the first clk_en cycle after rst deasserts.
- FSM states:
  - ACTIVE: normal operation.
  - DRAIN: done popped; waiting for the done handshake.
  - FINISHED: done=1, in_ready=0, out_valid=0.
  - Transitions: ACTIVE->DRAIN on popping a done item. DRAIN->FINISHED on done-token handshake. Any state->ACTIVE on flush.
- Input side:
  - in_ready = tile_en & !fifo_full & state==ACTIVE.
  - No write-through when full.
  - Kind 11 is accepted and dropped, and sets err.
  - Items accepted after a done item is in the FIFO are still stored; they are discarded at the next flush.
- Pop rule: the head is popped when the output register is empty, or is being handshaken this cycle (out_valid & out_ready).
- Pending-stop register (MERGE_STOPS=1):
  - A popped stop goes to pending and does not load the output.
  - A further popped stop while pending updates the pending level to max(pending, new).
  - A popped coord or done while pending: the stop loads the output register first. The coord/done stays at the FIFO head and is popped on the following load opportunity.
  - So a stop is emitted only after the next non-stop item arrives.
- MERGE_STOPS=0: stops load the output directly, like coords.
- Output register: once out_valid=1, out_data holds stable until out_ready. out_valid drops the cycle after handshake if nothing is loaded.
- Latency and throughput:
  - A coord accepted in cycle N is valid on out in cycle N+2 when out_ready=1 and nothing is pending.
  - Sustained throughput is 1 token/cycle.
- Simultaneous events:
  - FIFO push and pop in the same cycle: occupancy unchanged.
  - flush has priority over push, pop and handshake.
  - clk_en=0 freezes all registers; outputs hold.
- tok_count increments on every out handshake, including stop and done tokens. It is cleared by flush and rst.
- Reset or flush mid-stream: all queued and pending tokens are lost, and out_valid deasserts next cycle (immediately on rst).

Decomposition:
- Package crd_stream_pkg:
  - token kind enum (COORD, STOP, DONE, ILLEGAL)
  - TOKEN_W=17, DONE_TOKEN=17'h10100
  - stop/done encode functions
  - FSM state enum
- One sub-module: crd_stream_fifo (DEPTH x 18 bits: 16 data + 2 kind; full/empty flags; sync flush; async active-high rst).

Test Plan:
- Items coord 3, coord 7, stop 0, done with out_ready=1 -> out sequence 0x00003, 0x00007, 0x10000, 0x10100; first valid 2 cycles after first accept; done=1; tok_count=4.
- Stops lvl0, lvl1, lvl0 then coord 5 (MERGE_STOPS=1) -> out 0x10001 then 0x00005; with MERGE_STOPS=0 -> 0x10000, 0x10001, 0x10000, 0x00005.
- out_ready=0 while pushing 6 coords (DEPTH=4) -> in_ready low after 5 accepts (4 FIFO + 1 output register); out_data stable; releasing out_ready drains in order with no loss.
- Pending stop lvl2 followed by done -> 0x10002 then 0x10100; FSM reaches FINISHED; in_ready=0.
- Assert flush with 3 items queued and a pending stop -> out_valid=0 next cycle; tok_count=0; a subsequent coord 9 appears as 0x00009.
- in_kind=11 item -> err=1; no output token; stream otherwise unaffected. rst pulse mid-stream -> out_valid=0 immediately and err cleared.
